// File: rtl/iob_native_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : iob_native_mem_responder_if
// Description : IOb Native request/response bundle between an initiator and
//               the memory responder. Signal suffixes are from the responder's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface iob_native_mem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) ();
    logic                  iob_valid_i;
    logic [ADDR_W-1:0]     iob_addr_i;
    logic [DATA_W-1:0]     iob_wdata_i;
    logic [DATA_W/8-1:0]   iob_wstrb_i;
    logic                  iob_ready_o;
    logic                  iob_rvalid_o;
    logic [DATA_W-1:0]     iob_rdata_o;

    modport master (
        output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        input  iob_ready_o, iob_rvalid_o, iob_rdata_o
    );

    modport slave (
        input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        output iob_ready_o, iob_rvalid_o, iob_rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/iob_native_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : iob_native_mem_responder
// Description : IOb Native responder backed by a word RAM, with programmable
//               wait states, read latency, range checking and access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_native_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int READ_LAT    = 1,
    parameter int CNT_W       = 16
) (
    input  wire logic                 clk_i,
    input  wire logic                 arst_n_i,
    iob_native_mem_responder_if.slave iob,
    output logic                      err_o,
    output logic [CNT_W-1:0]          wr_cnt_o,
    output logic [CNT_W-1:0]          rd_cnt_o
);

    localparam int NB_W   = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << MEM_ADDR_W;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_STALL = 2'd1;
    localparam logic [1:0] c_ACK   = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);
    localparam logic [3:0] c_LAT  = 4'(READ_LAT);

    logic [1:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [3:0]        r_lat_cnt;
    logic              r_ready;
    logic              r_rvalid;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_cap;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;

    // RAM contents survive reset; only the power-up value is defined.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

    logic                  w_xfer;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_oob;
    logic [MEM_ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_unused_addr_lsb;

    // Ready is only ever high in ACK, so it alone qualifies the transfer.
    assign w_xfer    = r_ready && iob.iob_valid_i;
    assign w_wr      = w_xfer && (|iob.iob_wstrb_i);
    assign w_rd      = w_xfer && !(|iob.iob_wstrb_i);
    assign w_idx     = iob.iob_addr_i[MEM_ADDR_W+NB_W-1:NB_W];
    assign w_rd_word = w_oob ? '0 : r_mem[w_idx];

    assign w_unused_addr_lsb = ^iob.iob_addr_i[NB_W-1:0];

    generate
        if (ADDR_W > MEM_ADDR_W + NB_W) begin : g_range_chk
            assign w_oob = |iob.iob_addr_i[ADDR_W-1:MEM_ADDR_W+NB_W];
        end else begin : g_no_range_chk
            assign w_oob = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state    <= c_IDLE;
            r_wait_cnt <= 4'd0;
            r_lat_cnt  <= 4'd0;
            r_ready    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_cap      <= '0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= w_xfer && w_oob;
            case (r_state)
                c_IDLE: begin
                    if (iob.iob_valid_i) begin
                        if (c_WAIT == 4'd0) begin
                            r_state <= c_ACK;
                            r_ready <= 1'b1;
                        end else begin
                            r_state    <= c_STALL;
                            r_wait_cnt <= 4'd1;
                        end
                    end
                end
                c_STALL: begin
                    if (!iob.iob_valid_i) begin
                        r_state <= c_IDLE;
                    end else if (r_wait_cnt == c_WAIT) begin
                        r_state <= c_ACK;
                        r_ready <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                c_ACK: begin
                    r_state <= c_IDLE;
                    if (w_wr) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                    if (w_rd) begin
                        r_rd_cnt  <= r_rd_cnt + 1'b1;
                        r_cap     <= w_rd_word;
                        r_lat_cnt <= 4'd1;
                        r_state   <= c_RESP;
                        if (c_LAT == 4'd1) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_rd_word;
                        end
                    end
                end
                c_RESP: begin
                    // rvalid is launched one edge early so it lands when the count hits READ_LAT.
                    if (r_lat_cnt == c_LAT) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 4'd1;
                        if (r_lat_cnt + 4'd1 == c_LAT) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= r_cap;
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr && !w_oob) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (iob.iob_wstrb_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= iob.iob_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign iob.iob_ready_o  = r_ready;
    assign iob.iob_rvalid_o = r_rvalid;
    assign iob.iob_rdata_o  = r_rdata;
    assign err_o            = r_err;
    assign wr_cnt_o         = r_wr_cnt;
    assign rd_cnt_o         = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iob_native_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_native_mem_responder
// Description : Self-checking bench for iob_native_mem_responder against a
//               word-array memory model with cycle-exact handshake timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_native_mem_responder;

    localparam int WAIT  = 2;
    localparam int LAT   = 3;
    localparam int CNT_W = 4;

    logic             clk;
    logic             arst_n;
    logic             err;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;

    iob_native_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) iob ();

    iob_native_mem_responder #(
        .ADDR_W(16), .DATA_W(32), .MEM_ADDR_W(10),
        .WAIT_CYCLES(WAIT), .READ_LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .arst_n_i(arst_n), .iob(iob.slave),
        .err_o(err), .wr_cnt_o(wr_cnt), .rd_cnt_o(rd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [1024];
    int          wr_n = 0;
    int          rd_n = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        iob.iob_valid_i = 1'b0;
        arst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        wr_n = 0; rd_n = 0; last_rd = '0;
    endtask

    // One access from IDLE; expectations come from the model and the timing rules.
    task automatic access(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        bit          is_wr;
        bit          oob;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        int          ready_cyc, rv_cyc, err_cyc, n_ready, n_rv, n_err;
        is_wr  = (s != 4'd0);
        oob    = (a >= 16'h1000);
        exp_rd = oob ? 32'd0 : model[a / 4];
        ready_cyc = -1; rv_cyc = -1; err_cyc = -1;
        n_ready = 0; n_rv = 0; n_err = 0; rd = '0;
        @(posedge clk); #1;
        iob.iob_valid_i = 1'b1; iob.iob_addr_i = a; iob.iob_wdata_i = d; iob.iob_wstrb_i = s;
        for (int k = 0; k < 16; k++) begin
            if (iob.iob_ready_o) begin n_ready++; if (ready_cyc < 0) ready_cyc = k; end
            if (iob.iob_rvalid_o) begin n_rv++; rv_cyc = k; rd = iob.iob_rdata_o; end
            if (err) begin n_err++; err_cyc = k; end
            @(posedge clk); #1;
            if (k == ready_cyc) iob.iob_valid_i = 1'b0;
        end
        iob.iob_valid_i = 1'b0;
        check("ready_cycle", ready_cyc, 1 + WAIT);
        check("ready_pulses", n_ready, 1);
        check("err_pulses", n_err, oob ? 1 : 0);
        if (oob) check("err_cycle", err_cyc, 2 + WAIT);
        if (is_wr) begin
            check("wr_no_rvalid", n_rv, 0);
            check("rdata_hold", iob.iob_rdata_o, last_rd);
            if (!oob)
                for (int b = 0; b < 4; b++)
                    if (s[b]) model[a / 4][b*8 +: 8] = d[b*8 +: 8];
            wr_n++;
        end else begin
            check("rvalid_pulses", n_rv, 1);
            check("rvalid_cycle", rv_cyc, 1 + WAIT + LAT);
            check("rdata", rd, exp_rd);
            check("rdata_hold", iob.iob_rdata_o, exp_rd);
            last_rd = exp_rd;
            rd_n++;
        end
        check("wr_cnt", wr_cnt, wr_n % 16);
        check("rd_cnt", rd_cnt, rd_n % 16);
    endtask

    initial begin
        int          n_ready, n_rv;
        logic [15:0] ra;
        logic [3:0]  rs;

        for (int i = 0; i < 1024; i++) model[i] = '0;
        iob.iob_valid_i = 1'b0; iob.iob_addr_i = '0; iob.iob_wdata_i = '0; iob.iob_wstrb_i = '0;
        do_reset();

        check("rst_ready", iob.iob_ready_o, 0);
        check("rst_rvalid", iob.iob_rvalid_o, 0);
        check("rst_rdata", iob.iob_rdata_o, 0);
        check("rst_err", err, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_rd_cnt", rd_cnt, 0);

        for (int i = 0; i < 5; i++) access(16'(4 * i), 32'(12 * i), 4'hF);
        for (int i = 0; i < 5; i++) access(16'(4 * i), 32'h0, 4'h0);
        check("plan_wr_cnt5", wr_cnt, 5);
        check("plan_rd_cnt5", rd_cnt, 5);

        access(16'h0020, 32'hAABBCCDD, 4'hF);
        access(16'h0020, 32'h11223344, 4'h5);
        access(16'h0020, 32'h0, 4'h0);
        check("strobe_merge", last_rd, 32'hAA22CC44);

        access(16'h1000, 32'hDEADBEEF, 4'hF);
        access(16'h1000, 32'h0, 4'h0);
        access(16'h0000, 32'h0, 4'h0);
        check("oob_word0_intact", last_rd, 32'h0);
        access(16'h0010, 32'h0, 4'h0);
        check("oob_word4_intact", last_rd, 32'd48);

        // Initiator withdraws while stalled: no handshake, no count change.
        @(posedge clk); #1;
        iob.iob_valid_i = 1'b1; iob.iob_addr_i = 16'h0004; iob.iob_wstrb_i = 4'hF;
        @(posedge clk); #1;
        iob.iob_valid_i = 1'b0;
        n_ready = 0;
        for (int k = 0; k < 8; k++) begin
            if (iob.iob_ready_o) n_ready++;
            @(posedge clk); #1;
        end
        check("withdraw_no_ready", n_ready, 0);
        check("withdraw_wr_cnt", wr_cnt, wr_n % 16);
        check("withdraw_rd_cnt", rd_cnt, rd_n % 16);

        // Randomised accesses over a small window so reads hit written words.
        for (int i = 0; i < 24; i++) begin
            ra = 16'((($urandom % 16) + 32) * 4 + ($urandom % 4));
            rs = ($urandom % 2 == 0) ? 4'h0 : 4'(($urandom % 15) + 1);
            access(ra, $urandom, rs);
        end

        // Reset while the read is waiting in RESP.
        @(posedge clk); #1;
        iob.iob_valid_i = 1'b1; iob.iob_addr_i = 16'h0020; iob.iob_wstrb_i = 4'h0;
        repeat (1 + WAIT) @(posedge clk);
        #1 check("resp_ready_before_rst", iob.iob_ready_o, 1);
        @(posedge clk); #1;
        iob.iob_valid_i = 1'b0;
        arst_n = 1'b0;
        #2 check("resp_rst_ready", iob.iob_ready_o, 0);
        check("resp_rst_rd_cnt", rd_cnt, 0);
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        wr_n = 0; rd_n = 0; last_rd = '0;
        n_rv = 0;
        for (int k = 0; k < 10; k++) begin
            if (iob.iob_rvalid_o) n_rv++;
            @(posedge clk); #1;
        end
        check("resp_rst_no_rvalid", n_rv, 0);
        check("resp_rst_wr_cnt", wr_cnt, 0);
        check("resp_rst_rd_cnt_after", rd_cnt, 0);
        access(16'h0010, 32'h0, 4'h0);
        check("ram_kept_word4", last_rd, 32'd48);

        do_reset();
        for (int i = 0; i < 17; i++) access(16'(4 * (i % 8) + 256), $urandom, 4'hF);
        check("wr_cnt_wrap", wr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/iob_native_mem_responder.md
Name: iob_native_mem_responder

Overview:
- IOb Native subordinate (responder) backed by an internal word-organised RAM, with programmable wait states and read latency.
- Sits at the far end of an IOb Native link: the memory/back-end model that initiators (cache back-end, benches, CPU ports) talk to.
- Supports byte-strobed writes, single-outstanding reads, out-of-range detection and transaction counters.

Parameters:
- ADDR_W, 16, byte address width of iob_addr_i
- DATA_W, 32, data width; multiple of 8; NB_W = log2(DATA_W/8)
- MEM_ADDR_W, 10, log2 of RAM depth in words
- WAIT_CYCLES, 2, extra cycles iob_ready_o stays low after valid is first sampled (0..15)
- READ_LAT, 1, cycles from read acceptance edge to the iob_rvalid_o cycle (1..8)
- CNT_W, 16, width of transaction counters

Ports:
- clk_i  in  1  clock, rising edge
- arst_n_i  in  1  asynchronous reset, active low
- iob_valid_i  in  1  request valid
- iob_addr_i  in  ADDR_W  byte address; bits [NB_W-1:0] ignored
- iob_wdata_i  in  DATA_W  write data
- iob_wstrb_i  in  DATA_W/8  byte strobes; nonzero = write, zero = read
- iob_ready_o  out  1  request accepted this cycle (registered)
- iob_rvalid_o  out  1  read data valid (registered, 1-cycle pulse)
- iob_rdata_o  out  DATA_W  read data (registered)
- err_o  out  1  1-cycle pulse: accepted access was out of range
- wr_cnt_o  out  CNT_W  accepted writes, wraps modulo 2^CNT_W
- rd_cnt_o  out  CNT_W  accepted reads, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock clk_i; reset arst_n_i is asynchronous, active low.
- Reset values: iob_ready_o=0, iob_rvalid_o=0, iob_rdata_o=0, err_o=0, both counters=0, FSM=IDLE, wait counter=0, latency counter=0.
- RAM is not reset. It is zero-initialised at time zero and preserved across reset.
- Transfer rule: a transfer occurs on a rising edge where iob_valid_i=1 and iob_ready_o=1. Address, wdata and wstrb are sampled on that edge.
- FSM states: IDLE, STALL, ACK, RESP.
- IDLE: iob_ready_o=0. If valid is sampled high: go to ACK when WAIT_CYCLES=0; otherwise go to STALL with wait counter=1.
- STALL: if valid is sampled low, return to IDLE with no access (initiator withdrew). If counter=WAIT_CYCLES, go to ACK; otherwise counter+1.
- ACK: iob_ready_o=1 for exactly one cycle, so ready is high in cycle N+1+WAIT_CYCLES, where N is the first cycle valid was sampled. On the ACK edge:
  - write: RAM bytes with strobe set are updated; wr_cnt+1; go to IDLE.
  - read: rd_cnt+1; capture the word; latency counter=1; go to RESP.
- RESP: iob_ready_o=0, so new requests are stalled (single outstanding read). When latency counter=READ_LAT: iob_rvalid_o=1 with iob_rdata_o for exactly one cycle, then go to IDLE. Otherwise latency counter+1.
- Read latency: rvalid is high in cycle A+READ_LAT, where A is the acceptance cycle.
- Writes never produce rvalid.
- iob_rdata_o holds its last value outside rvalid.
- Word index = iob_addr_i[MEM_ADDR_W+NB_W-1:NB_W].
- Out of range: iob_addr_i[ADDR_W-1:MEM_ADDR_W+NB_W] nonzero. The write is dropped (counter still increments); a read returns 0 with normal rvalid timing. err_o pulses in the cycle after the ACK edge.
- Back-to-back requests: valid held high after a write ACK is re-sampled in IDLE. Minimum write spacing is 2+WAIT_CYCLES cycles.
- Valid held high during RESP is ignored until IDLE.
- Write after read to the same address: the read returns the pre-write data, because reads are captured at acceptance.
- Counters wrap from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-transaction: FSM returns to IDLE immediately. A pending rvalid is discarded; a RAM write completes only if its ACK edge occurred before reset.

Test Plan:
- Reset, then write addr 0,4,8,12,16 with data 0,12,24,36,48, wstrb=0xF, then read each -> rdata equals 3*addr; rvalid exactly 1 cycle each; wr_cnt=5, rd_cnt=5.
- WAIT_CYCLES=2, READ_LAT=3: single read asserted in cycle 0 -> ready high in cycle 3 only; rvalid high in cycle 6 only.
- Write 0xAABBCCDD to addr 0x20, then write 0x11223344 with wstrb=0x5 -> read returns 0xAA22CC44.
- Access addr 0x1000 (out of range, MEM_ADDR_W=10) -> write dropped, err_o one pulse; a read returns 0 with err_o; no RAM word changes.
- Valid asserted for 1 cycle then dropped during STALL -> no ready, no counter change; drive reset low while in RESP -> rvalid never asserts, counters=0, RAM data still readable afterwards.
- CNT_W=4: 17 writes -> wr_cnt_o=1.
